// File: rtl/des_key_schedule_if.sv
// ============================================================================
// Module      : des_key_schedule_if
// Description : Key-load, start and subkey handshake bundle for the DES key
//               schedule engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface des_key_schedule_if;
  logic        key_wr;
  logic [1:0]  key_wr_slot;
  logic [63:0] key_in;
  logic        start_valid;
  logic        start_ready;
  logic [1:0]  start_slot;
  logic        start_decrypt;
  logic        abort;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [47:0] subkey;
  logic [3:0]  subkey_round;
  logic        done;
  logic        key_parity_err;
  logic        busy;

  modport slave (
    input  key_wr, key_wr_slot, key_in,
    input  start_valid, start_slot, start_decrypt, abort,
    output start_ready,
    output subkey_valid, subkey, subkey_round,
    input  subkey_ready,
    output done, key_parity_err, busy
  );

  modport master (
    output key_wr, key_wr_slot, key_in,
    output start_valid, start_slot, start_decrypt, abort,
    input  start_ready,
    input  subkey_valid, subkey, subkey_round,
    output subkey_ready,
    input  done, key_parity_err, busy
  );
endinterface

`default_nettype wire

// File: rtl/des_key_schedule.sv
// ============================================================================
// Module      : des_key_schedule
// Description : DES/3DES key schedule; emits 16 PC-2 subkeys in encrypt or
//               decrypt order over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module des_key_schedule #(
  parameter int N_KEYS       = 3,
  parameter bit PARITY_CHECK = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  des_key_schedule_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_LAST = 2'd3
  } state_t;

  localparam logic [2:0] c_n_keys = 3'(N_KEYS);

  localparam logic [447:0] c_pc1 = {
    8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,
    8'd1,  8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18,
    8'd10, 8'd2,  8'd59, 8'd51, 8'd43, 8'd35, 8'd27,
    8'd19, 8'd11, 8'd3,  8'd60, 8'd52, 8'd44, 8'd36,
    8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15,
    8'd7,  8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22,
    8'd14, 8'd6,  8'd61, 8'd53, 8'd45, 8'd37, 8'd29,
    8'd21, 8'd13, 8'd5,  8'd28, 8'd20, 8'd12, 8'd4
  };

  localparam logic [383:0] c_pc2 = {
    8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,
    8'd3,  8'd28, 8'd15, 8'd6,  8'd21, 8'd10,
    8'd23, 8'd19, 8'd12, 8'd4,  8'd26, 8'd8,
    8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,
    8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55,
    8'd30, 8'd40, 8'd51, 8'd45, 8'd33, 8'd48,
    8'd44, 8'd49, 8'd39, 8'd56, 8'd34, 8'd53,
    8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32
  };

  // Table entries are 1-based DES bit numbers; DES bit 1 is the MSB.
  function automatic logic [55:0] f_pc1(input logic [63:0] k);
    logic [55:0] r;
    int          src;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      src       = int'(c_pc1[(55 - i) * 8 +: 8]);
      r[55 - i] = k[64 - src];
    end
    return r;
  endfunction

  function automatic logic [47:0] f_pc2(input logic [27:0] c, input logic [27:0] d);
    logic [55:0] cd;
    logic [47:0] r;
    int          src;
    cd = {c, d};
    r  = '0;
    for (int j = 0; j < 48; j++) begin
      src       = int'(c_pc2[(47 - j) * 8 +: 8]);
      r[47 - j] = cd[56 - src];
    end
    return r;
  endfunction

  function automatic logic [27:0] f_rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] f_rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  state_t      r_state, w_state_nxt;
  logic [27:0] r_c, r_d, w_c_nxt, w_d_nxt;
  logic        r_dec, w_dec_nxt;
  logic [47:0] r_subkey, w_subkey_nxt;
  logic [3:0]  r_round, w_round_nxt;
  logic [3:0]  r_count, w_count_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_done, w_done_nxt;
  logic        r_parity_err;
  logic [63:0] r_slot [4];

  logic        w_hs;
  logic        w_wr_ok;
  logic        w_par_bad;
  logic [1:0]  w_sel;
  logic [55:0] w_cd0;
  logic [3:0]  w_sidx;
  logic        w_two;
  logic        w_load_sk;

  assign w_hs    = r_valid & bus.subkey_ready;
  assign w_wr_ok = bus.key_wr & ({1'b0, bus.key_wr_slot} < c_n_keys);
  assign w_sel   = ({1'b0, bus.start_slot} < c_n_keys) ? bus.start_slot : 2'd0;
  assign w_cd0   = f_pc1(r_slot[w_sel]);

  // Shift-table index of the step being taken: the next round when
  // encrypting, the current round when walking backwards.
  assign w_sidx  = r_dec ? r_round : (r_round + 4'd1);
  assign w_two   = !((w_sidx == 4'd0) || (w_sidx == 4'd1) ||
                     (w_sidx == 4'd8) || (w_sidx == 4'd15));

  generate
    if (PARITY_CHECK) begin : g_parity
      always_comb begin
        w_par_bad = 1'b0;
        for (int b = 0; b < 8; b++) begin
          if (~^bus.key_in[b * 8 +: 8]) w_par_bad = 1'b1;
        end
      end
    end else begin : g_no_parity
      assign w_par_bad = 1'b0;
    end
  endgenerate

  always_comb begin
    w_state_nxt  = r_state;
    w_c_nxt      = r_c;
    w_d_nxt      = r_d;
    w_dec_nxt    = r_dec;
    w_subkey_nxt = r_subkey;
    w_round_nxt  = r_round;
    w_count_nxt  = r_count;
    w_valid_nxt  = r_valid;
    w_done_nxt   = 1'b0;
    w_load_sk    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start_valid) begin
          w_c_nxt     = w_cd0[55:28];
          w_d_nxt     = w_cd0[27:0];
          w_dec_nxt   = bus.start_decrypt;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (bus.abort) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          // Decrypt starts at K16, whose cumulative rotation of 28 is identity.
          if (!r_dec) begin
            w_c_nxt     = f_rotl(r_c, 1'b0);
            w_d_nxt     = f_rotl(r_d, 1'b0);
            w_round_nxt = 4'd0;
          end else begin
            w_round_nxt = 4'd15;
          end
          w_load_sk   = 1'b1;
          w_count_nxt = 4'd0;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (w_hs) begin
          if (r_dec) begin
            w_c_nxt     = f_rotr(r_c, w_two);
            w_d_nxt     = f_rotr(r_d, w_two);
            w_round_nxt = r_round - 4'd1;
          end else begin
            w_c_nxt     = f_rotl(r_c, w_two);
            w_d_nxt     = f_rotl(r_d, w_two);
            w_round_nxt = r_round + 4'd1;
          end
          w_load_sk   = 1'b1;
          w_count_nxt = r_count + 4'd1;
          if (r_count == 4'd14) w_state_nxt = S_LAST;
        end
      end
      S_LAST: begin
        if (bus.abort) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (w_hs) begin
          w_valid_nxt = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_load_sk) w_subkey_nxt = f_pc2(w_c_nxt, w_d_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_c      <= '0;
      r_d      <= '0;
      r_dec    <= 1'b0;
      r_subkey <= '0;
      r_round  <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_c      <= w_c_nxt;
      r_d      <= w_d_nxt;
      r_dec    <= w_dec_nxt;
      r_subkey <= w_subkey_nxt;
      r_round  <= w_round_nxt;
      r_count  <= w_count_nxt;
      r_valid  <= w_valid_nxt;
      r_done   <= w_done_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_slot[i] <= '0;
      r_parity_err <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_wr_ok && (bus.key_wr_slot == 2'(i))) r_slot[i] <= bus.key_in;
      end
      if (w_wr_ok && w_par_bad) r_parity_err <= 1'b1;
    end
  end

  assign bus.start_ready    = (r_state == S_IDLE);
  assign bus.busy           = (r_state != S_IDLE);
  assign bus.subkey_valid   = r_valid;
  assign bus.subkey         = r_subkey;
  assign bus.subkey_round   = r_round;
  assign bus.done           = r_done;
  assign bus.key_parity_err = r_parity_err;

endmodule

`default_nettype wire

// File: tb/tb_des_key_schedule.sv
// ============================================================================
// Module      : tb_des_key_schedule
// Description : Scoreboard bench for des_key_schedule using the classic
//               133457799BBCDFF1 subkey vector plus all-zero/all-one keys.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_des_key_schedule;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  des_key_schedule_if bus();

  des_key_schedule #(.N_KEYS(3), .PARITY_CHECK(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  localparam logic [63:0] c_key_std  = 64'h133457799BBCDFF1;
  localparam logic [63:0] c_key_zero = 64'h0101010101010101;
  localparam logic [63:0] c_key_ones = 64'hFEFEFEFEFEFEFEFE;

  localparam logic [47:0] c_k [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  int          n_checks = 0;
  int          n_pass   = 0;
  int          hs_cnt   = 0;
  int          hs_base  = 0;
  int          done_cnt = 0;
  bit          bp_mode  = 1'b0;
  logic [51:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Consumer ready: always on, or random when backpressure is enabled.
  initial begin
    bus.subkey_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.subkey_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every handshake, checks stall stability.
  initial begin
    logic        stalled;
    logic [51:0] held;
    logic [51:0] e;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled && bus.subkey_valid)
          check("stall_hold", {bus.subkey_round, bus.subkey}, held);
        if (bus.done) done_cnt++;
        if (bus.subkey_valid && bus.subkey_ready && !bus.abort) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_subkey: got round %0d subkey %h, none expected",
                     bus.subkey_round, bus.subkey);
          end else begin
            e = exp_q.pop_front();
            check("subkey", {bus.subkey_round, bus.subkey}, e);
          end
        end
        stalled = bus.subkey_valid && !bus.subkey_ready && !bus.abort;
        held    = {bus.subkey_round, bus.subkey};
      end
    end
  end

  task automatic write_key(input logic [1:0] s, input logic [63:0] k);
    bus.key_wr      = 1'b1;
    bus.key_wr_slot = s;
    bus.key_in      = k;
    @(posedge clk);
    #1;
    bus.key_wr      = 1'b0;
  endtask

  // kind: 0 = standard vector, 1 = all-zero subkeys, 2 = all-one subkeys
  task automatic start_run(input logic [1:0] s, input logic dec, input int kind, input int npush);
    int          r;
    logic [47:0] v;
    check("start_ready_idle", bus.start_ready, 1);
    for (int i = 0; i < npush; i++) begin
      r = dec ? 15 - i : i;
      v = (kind == 0) ? c_k[r] : (kind == 1) ? 48'h0 : 48'hFFFFFFFFFFFF;
      exp_q.push_back({4'(r), v});
    end
    hs_base           = hs_cnt;
    bus.start_valid   = 1'b1;
    bus.start_slot    = s;
    bus.start_decrypt = dec;
    @(posedge clk);
    #1;
    bus.start_valid   = 1'b0;
  endtask

  task automatic wait_done(input bit timed);
    int d0;
    int c;
    bit seen;
    d0   = done_cnt;
    seen = 1'b0;
    for (c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (timed && c == 1) check("load_no_valid", bus.subkey_valid, 0);
      if (timed && c == 2) check("first_valid", bus.subkey_valid, 1);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL done_timeout: got no done in 400 cycles, required one");
    end else if (timed) begin
      check("done_cycle", c, 18);
      check("ready_at_done", bus.start_ready, 1);
      check("valid_at_done", bus.subkey_valid, 0);
    end
    repeat (3) @(posedge clk);
    #1;
    check("single_done", done_cnt - d0, 1);
    check("handshakes", hs_cnt - hs_base, 16);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    bus.key_wr        = 1'b0;
    bus.key_wr_slot   = 2'd0;
    bus.key_in        = '0;
    bus.start_valid   = 1'b0;
    bus.start_slot    = 2'd0;
    bus.start_decrypt = 1'b0;
    bus.abort         = 1'b0;
    rst_n             = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_start_ready", bus.start_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.subkey_valid, 0);
    check("rst_subkey", bus.subkey, 0);
    check("rst_round", bus.subkey_round, 0);
    check("rst_done", bus.done, 0);
    check("rst_parity", bus.key_parity_err, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    write_key(2'd0, c_key_std);
    write_key(2'd1, c_key_zero);
    write_key(2'd2, c_key_ones);
    check("parity_clean", bus.key_parity_err, 0);

    // Encrypt and decrypt, full throughput, with latency checks
    start_run(2'd0, 1'b0, 0, 16);
    check("busy_running", bus.busy, 1);
    wait_done(1'b1);
    start_run(2'd0, 1'b1, 0, 16);
    wait_done(1'b1);

    // Random backpressure
    bp_mode = 1'b1;
    start_run(2'd0, 1'b0, 0, 16);
    wait_done(1'b0);
    start_run(2'd0, 1'b1, 0, 16);
    wait_done(1'b0);
    bp_mode = 1'b0;

    // Distinct slots
    start_run(2'd1, 1'b0, 1, 16);
    wait_done(1'b0);
    start_run(2'd2, 1'b1, 2, 16);
    wait_done(1'b0);

    // Slot 3 is out of range: write dropped, start falls back to slot 0
    write_key(2'd3, c_key_ones);
    start_run(2'd3, 1'b0, 0, 16);
    wait_done(1'b0);

    // Rewriting the active slot leaves the run untouched
    start_run(2'd1, 1'b0, 1, 16);
    write_key(2'd1, c_key_std);
    wait_done(1'b0);
    start_run(2'd1, 1'b0, 0, 16);
    wait_done(1'b0);

    // Sticky parity error
    write_key(2'd2, 64'h133457799BBCDFF0);
    check("parity_set", bus.key_parity_err, 1);
    write_key(2'd2, c_key_zero);
    check("parity_sticky", bus.key_parity_err, 1);

    // Abort while round 5 is presented, racing a handshake
    d0 = done_cnt;
    start_run(2'd0, 1'b0, 0, 5);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.subkey_valid && bus.subkey_ready && bus.subkey_round == 4'd4) break;
    end
    @(posedge clk);
    #1;
    check("abort_round", bus.subkey_round, 5);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    check("abort_valid", bus.subkey_valid, 0);
    check("abort_ready", bus.start_ready, 1);
    check("abort_busy", bus.busy, 0);
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_handshakes", hs_cnt - hs_base, 5);
    check("abort_queue", exp_q.size(), 0);

    // Reset mid-run
    start_run(2'd0, 1'b0, 0, 16);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_valid", bus.subkey_valid, 0);
    check("mid_rst_subkey", bus.subkey, 0);
    check("mid_rst_round", bus.subkey_round, 0);
    check("mid_rst_ready", bus.start_ready, 1);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_parity", bus.key_parity_err, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Slots were cleared, so slot 0 now yields all-zero subkeys
    start_run(2'd0, 1'b0, 1, 16);
    wait_done(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
- Full DES/3DES key-schedule engine.
- Holds N_KEYS 64-bit key slots. On a start request it applies PC-1 to the selected slot, performs the per-round C/D rotations in encrypt or decrypt order, and applies PC-2 to emit the 16 48-bit round subkeys one at a time over a valid/ready handshake.
- Sits between key-load control and the Feistel round datapath. The round datapath consumes one subkey per handshake.

Parameters:
- N_KEYS, 3, number of key slots (1..4); 3 supports 3DES K1/K2/K3.
- PARITY_CHECK, 1, 1 = check odd parity per key byte on write; 0 = key_parity_err tied low.

Ports:
- clk  in  1  single clock; all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- key_wr  in  1  write key_in into slot key_wr_slot this cycle.
- key_wr_slot  in  2  target slot.
- key_in  in  64  key; bit 64 = DES bit 1 (MSB-first, index = 65 - DES bit number).
- start_valid  in  1  request a schedule run.
- start_ready  out  1  high only in IDLE.
- start_slot  in  2  slot to schedule.
- start_decrypt  in  1  0 = emit K1..K16; 1 = emit K16..K1.
- abort  in  1  synchronous abort of a run.
- subkey_valid  out  1  subkey presented.
- subkey_ready  in  1  consumer accepts.
- subkey  out  48  bit 48 = PC-2 output bit 1.
- subkey_round  out  4  DES round number of presented subkey minus 1 (K1 = 0, K16 = 15).
- done  out  1  one-cycle pulse after 16th subkey handshake.
- key_parity_err  out  1  sticky parity error.
- busy  out  1  not IDLE.

Behaviour:
- Reset (async, rst_n low):
  - outputs: start_ready = 1, busy = 0, subkey_valid = 0, subkey = 0, subkey_round = 0, done = 0, key_parity_err = 0.
  - internal: key slots = 0, state = IDLE.
- Key writes:
  - Accepted in any state.
  - key_wr_slot >= N_KEYS: write ignored.
  - A write to the slot in use does not affect a run in progress, because C/D are already latched.
  - PARITY_CHECK = 1: key_parity_err set if any byte of key_in has even parity. Key is stored anyway. Flag cleared only by reset.
- States: IDLE, LOAD, RUN, LAST.
  - IDLE: start_ready = 1.
    - start_valid at edge T: latch start_decrypt; C/D <= PC-1(slot). Go LOAD.
    - start_slot >= N_KEYS selects slot 0.
  - LOAD: one cycle. Compute first subkey:
    - encrypt: rotate C, D left by 1, then PC-2 gives K1.
    - decrypt: no rotation (cumulative shift is 28), PC-2(C0D0) gives K16.
    - Register the result into subkey; subkey_valid = 1 from edge T+2. Go RUN.
  - RUN: hold subkey, subkey_round and subkey_valid stable while subkey_ready = 0. On a handshake, load the next subkey the same edge (no bubble; sustained 1 subkey/cycle).
    - Encrypt shift for round r: left 1 for r in {1,2,9,16}, else left 2.
    - Decrypt: to go from K(r) to K(r-1), rotate right by shift(r).
    - When the 16th subkey is loaded, go LAST.
  - LAST: on handshake, subkey_valid = 0, done = 1 for one cycle, then IDLE.
- Fastest run: start at T; subkeys handshake at T+2..T+17; done high in cycle T+18; start_ready high again T+18.
- abort (RUN/LOAD/LAST): next edge subkey_valid = 0, state IDLE, no done pulse. abort in IDLE has no effect. abort beats a simultaneous handshake.
- rst_n low mid-run: immediate return to reset values; slots cleared.
- Rotation is 28-bit circular, independent on C (PC-1 upper half) and D.
- PC-1 discards parity bits 8, 16, ..., 64. PC-2 discards C/D bits 9, 18, 22, 25, 35, 38, 43, 54.

Test Plan:
- Encrypt vector: write 64'h133457799BBCDFF1 to slot 0, start encrypt, subkey_ready = 1 → first subkey 48'h1B02EFFC7072 with round 0 at T+2; last 48'hCB3D8B0E17F5 with round 15 at T+17; done at T+18.
- Decrypt order: same key, start_decrypt = 1 → first subkey 48'hCB3D8B0E17F5 with round 15; last 48'h1B02EFFC7072 with round 0. The full sequence equals the encrypt sequence reversed.
- Backpressure: toggle subkey_ready randomly → subkey and subkey_round stable while stalled; exactly 16 handshakes; single done pulse.
- Slots/3DES: distinct keys in slots 0–2; write slot 3 with N_KEYS = 3 → ignored (slot 3 start schedules slot 0). Rewrite slot 1 mid-run → current run's subkeys unchanged.
- Parity: write 64'h133457799BBCDFF0 → key_parity_err = 1 and stays set. Write 64'h0101010101010101 → no new error.
- Abort/reset: abort at round 5 → subkey_valid low next cycle, no done, start_ready = 1. rst_n low mid-run → all outputs at reset values immediately.
